// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and architectural register indices for the scoreboarded register file.
package rf_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam logic [31:0] SP_INIT_DEF = 32'h7fffeffc;
   localparam logic [31:0] GP_INIT_DEF = 32'h10008000;
   localparam int X0_IDX = 0;
   localparam int X2_IDX = 2;
   localparam int X3_IDX = 3;
endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for the register file: read ports, write ports, issue port and busy count.
interface reg_file_sb_if import rf_pkg::*; #(
   parameter int ADDRESS_WIDTH = ADDR_W_DEF,
   parameter int DATA_WIDTH    = DATA_W_DEF,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 2
);
   logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0] ra;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd;
   logic [NUM_RD-1:0]                    rd_busy;
   logic [NUM_WR-1:0]                    we;
   logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wa;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wd;
   logic                                 iss_valid;
   logic [ADDRESS_WIDTH-1:0]             iss_addr;
   logic [ADDRESS_WIDTH:0]               busy_cnt;

   modport master (output ra, we, wa, wd, iss_valid, iss_addr,
                   input  rd, rd_busy, busy_cnt);
   modport slave  (input  ra, we, wa, wd, iss_valid, iss_addr,
                   output rd, rd_busy, busy_cnt);
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running population count.
module rf_scoreboard import rf_pkg::*; #(
   parameter int ADDRESS_WIDTH = ADDR_W_DEF,
   parameter int NUM_WR        = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_WR-1:0]                    we_i,
   input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wa_i,
   input  logic                                 iss_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]             iss_addr_i,
   output logic [2**ADDRESS_WIDTH-1:0]          busy_o,
   output logic [ADDRESS_WIDTH:0]               busy_cnt_o
);
   localparam int DEPTH = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] CNT_ONE = 1;

   logic [DEPTH-1:0]       busy_q, busy_d, set_vec, clr_vec, drop_vec;
   logic [ADDRESS_WIDTH:0] cnt_q, cnt_d;

   // A same-edge issue wins over a commit clear, so drop only bits not being re-set.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid_i) set_vec[iss_addr_i] = 1'b1;
      for (int j = 0; j < NUM_WR; j++) begin
         if (we_i[j]) clr_vec[wa_i[j]] = 1'b1;
      end
      set_vec[X0_IDX] = 1'b0;
      drop_vec = busy_q & clr_vec & ~set_vec;
      busy_d   = (busy_q & ~drop_vec) | set_vec;
      busy_d[X0_IDX] = 1'b0;
      cnt_d = cnt_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (set_vec[k] && !busy_q[k]) cnt_d = cnt_d + CNT_ONE;
         if (drop_vec[k])              cnt_d = cnt_d - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o     = busy_q;
   assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with x0 hardwired to zero, optional write forwarding and a busy scoreboard.
module reg_file_sb import rf_pkg::*; #(
   parameter int                    ADDRESS_WIDTH = ADDR_W_DEF,
   parameter int                    DATA_WIDTH    = DATA_W_DEF,
   parameter int                    NUM_RD        = 2,
   parameter int                    NUM_WR        = 2,
   parameter logic [DATA_WIDTH-1:0] SP_INIT       = SP_INIT_DEF,
   parameter logic [DATA_WIDTH-1:0] GP_INIT       = GP_INIT_DEF,
   parameter int                    BYPASS        = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]      busy;

   rf_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_WR        (NUM_WR)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .we_i        (bus.we),
      .wa_i        (bus.wa),
      .iss_valid_i (bus.iss_valid),
      .iss_addr_i  (bus.iss_addr),
      .busy_o      (busy),
      .busy_cnt_o  (bus.busy_cnt)
   );

   // Later write ports are applied last, so the highest port wins an address clash.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
         regs_q[X2_IDX] <= SP_INIT;
         regs_q[X3_IDX] <= GP_INIT;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.we[j] && (bus.wa[j] != '0)) regs_q[bus.wa[j]] <= bus.wd[j];
         end
      end
   end

   always_comb begin
      bus.rd      = '0;
      bus.rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic fwd;
         fwd = 1'b0;
         bus.rd[i] = regs_q[bus.ra[i]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (bus.we[j] && (bus.wa[j] == bus.ra[i])) begin
                  bus.rd[i] = bus.wd[j];
                  fwd       = 1'b1;
               end
            end
         end
         bus.rd_busy[i] = busy[bus.ra[i]] & ~fwd;
         if (bus.ra[i] == '0) begin
            bus.rd[i]      = '0;
            bus.rd_busy[i] = 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus a randomized phase against a reference model.
module tb_reg_file_sb;
   import rf_pkg::*;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_file_sb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

   reg_file_sb #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .NUM_RD        (NRD),
      .NUM_WR        (NWR),
      .SP_INIT       (SP_INIT_DEF),
      .GP_INIT       (GP_INIT_DEF),
      .BYPASS        (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] mdl_mem  [32];
   logic        mdl_busy [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_of(input int sel);
      case (sel)
         0:       return bus.rd[0];
         1:       return bus.rd[1];
         2:       return {31'b0, bus.rd_busy[0]};
         3:       return {31'b0, bus.rd_busy[1]};
         default: return {26'b0, bus.busy_cnt};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.sel = sel;
      x.exp = e;
      exp_q.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk(x.tag, obs_of(x.sel), x.exp);
      end
   endtask

   task automatic idle();
      bus.we        = '0;
      bus.iss_valid = 1'b0;
      bus.iss_addr  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mdl_reset();
      for (int k = 0; k < 32; k++) begin
         mdl_mem[k]  = '0;
         mdl_busy[k] = 1'b0;
      end
      mdl_mem[2] = SP_INIT_DEF;
      mdl_mem[3] = GP_INIT_DEF;
   endtask

   function automatic int mdl_cnt();
      int c;
      c = 0;
      for (int k = 0; k < 32; k++) c += int'(mdl_busy[k]);
      return c;
   endfunction

   task automatic mdl_read(input int a, output logic [31:0] v, output logic b);
      logic byp;
      byp = 1'b0;
      v   = mdl_mem[a];
      for (int j = 0; j < NWR; j++) begin
         if (bus.we[j] && int'(bus.wa[j]) == a) begin
            v   = bus.wd[j];
            byp = 1'b1;
         end
      end
      b = mdl_busy[a] && !byp;
      if (a == 0) begin
         v = '0;
         b = 1'b0;
      end
   endtask

   task automatic mdl_commit();
      logic [31:0] clr;
      clr = '0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.we[j]) begin
            clr[bus.wa[j]] = 1'b1;
            if (bus.wa[j] != 0) mdl_mem[bus.wa[j]] = bus.wd[j];
         end
      end
      for (int k = 1; k < 32; k++) if (clr[k]) mdl_busy[k] = 1'b0;
      if (bus.iss_valid && bus.iss_addr != 0) mdl_busy[bus.iss_addr] = 1'b1;
   endtask

   initial begin
      logic [31:0] v;
      logic        b;
      rst_n   = 1'b0;
      bus.ra  = '0;
      bus.wa  = '0;
      bus.wd  = '0;
      idle();

      // reset state
      #12;
      push("rst_cnt_held", 4, 0);
      drain();
      rst_n     = 1'b1;
      bus.ra[0] = 5'd2;
      bus.ra[1] = 5'd3;
      #1;
      push("rst_sp", 0, 32'h7fffeffc);
      push("rst_gp", 1, 32'h10008000);
      push("rst_cnt", 4, 0);
      drain();
      bus.ra[0] = 5'd5;
      #1;
      push("rst_x5", 0, 0);
      push("rst_x5_busy", 2, 0);
      drain();

      // x0 writes and issues are ignored
      tick();
      bus.we[0] = 1'b1;  bus.wa[0] = 5'd0;  bus.wd[0] = 32'hdeadbeef;
      bus.iss_valid = 1'b1;  bus.iss_addr = 5'd0;
      bus.ra[0] = 5'd0;
      #2;
      push("x0_byp", 0, 0);
      push("x0_busy", 2, 0);
      drain();
      tick();
      idle();
      #2;
      push("x0_rd", 0, 0);
      push("x0_cnt", 4, 0);
      drain();

      // bypass with write-port conflict
      bus.we = 2'b11;
      bus.wa[0] = 5'd7;  bus.wa[1] = 5'd7;
      bus.wd[0] = 32'h11;  bus.wd[1] = 32'h22;
      bus.ra[0] = 5'd7;
      #2;
      push("byp_same_cycle", 0, 32'h22);
      push("byp_busy", 2, 0);
      drain();
      tick();
      idle();
      bus.ra[1] = 5'd7;
      #2;
      push("byp_stored0", 0, 32'h22);
      push("byp_stored1", 1, 32'h22);
      drain();

      // issue then write x5
      bus.iss_valid = 1'b1;  bus.iss_addr = 5'd5;
      tick();
      idle();
      bus.ra[0] = 5'd5;
      #2;
      push("sb_cnt1", 4, 1);
      push("sb_busy5", 2, 1);
      drain();
      bus.we[0] = 1'b1;  bus.wa[0] = 5'd5;  bus.wd[0] = 32'ha5;
      #1;
      push("sb_wr_busy", 2, 0);
      push("sb_wr_byp", 0, 32'ha5);
      drain();
      tick();
      idle();
      #2;
      push("sb_cnt0", 4, 0);
      push("sb_rd5", 0, 32'ha5);
      push("sb_busy5_clr", 2, 0);
      drain();

      // simultaneous set and clear
      bus.iss_valid = 1'b1;  bus.iss_addr = 5'd9;
      tick();
      idle();
      bus.ra[0] = 5'd9;
      #2;
      push("sim_cnt1", 4, 1);
      push("sim_busy9", 2, 1);
      drain();
      bus.iss_valid = 1'b1;  bus.iss_addr = 5'd9;
      bus.we[0] = 1'b1;  bus.wa[0] = 5'd9;  bus.wd[0] = 32'h99;
      tick();
      idle();
      #2;
      push("sim_set_wins_cnt", 4, 1);
      push("sim_set_wins_busy", 2, 1);
      push("sim_x9_data", 0, 32'h99);
      drain();
      bus.iss_valid = 1'b1;  bus.iss_addr = 5'd10;
      bus.we[0] = 1'b1;  bus.wa[0] = 5'd9;  bus.wd[0] = 32'h990;
      bus.ra[1] = 5'd10;
      #1;
      push("sim_x10_pre", 3, 0);
      push("sim_x9_byp_busy", 2, 0);
      push("sim_x9_byp", 0, 32'h990);
      drain();
      tick();
      idle();
      #2;
      push("sim_net_cnt", 4, 1);
      push("sim_x9_free", 2, 0);
      push("sim_x10_busy", 3, 1);
      drain();

      // async reset with pending operations
      bus.we = 2'b11;
      bus.wa[0] = 5'd10;  bus.wd[0] = 32'h10;
      bus.wa[1] = 5'd4;   bus.wd[1] = 32'h44;
      tick();
      idle();
      #2;
      push("mr_clear_cnt", 4, 0);
      drain();
      for (int a = 4; a <= 8; a++) begin
         bus.iss_valid = 1'b1;
         bus.iss_addr  = 5'(a);
         tick();
      end
      idle();
      bus.ra[0] = 5'd4;
      bus.ra[1] = 5'd2;
      #2;
      push("mr_cnt5", 4, 5);
      push("mr_x4_pre", 0, 32'h44);
      push("mr_x4_busy_pre", 2, 1);
      drain();
      bus.iss_valid = 1'b1;  bus.iss_addr = 5'd9;
      bus.we[0] = 1'b1;  bus.wa[0] = 5'd4;  bus.wd[0] = 32'hbad;
      #1;
      rst_n = 1'b0;
      #1;
      push("mr_cnt_async", 4, 0);
      push("mr_x4_busy", 2, 0);
      push("mr_sp", 1, SP_INIT_DEF);
      drain();
      tick();
      idle();
      #1;
      push("mr_x4_zero", 0, 0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #2;
      push("mr_cnt_after", 4, 0);
      push("mr_x4_after", 0, 0);
      drain();

      // randomized phase against the reference model
      mdl_reset();
      for (int it = 0; it < 80; it++) begin
         for (int j = 0; j < NWR; j++) begin
            bus.we[j] = 1'($urandom_range(0, 1));
            bus.wa[j] = 5'($urandom_range(0, 7));
            bus.wd[j] = $urandom;
         end
         bus.iss_valid = 1'($urandom_range(0, 1));
         bus.iss_addr  = 5'($urandom_range(0, 7));
         bus.ra[0]     = 5'($urandom_range(0, 7));
         bus.ra[1]     = 5'($urandom_range(0, 7));
         #2;
         mdl_read(int'(bus.ra[0]), v, b);
         push("rnd_rd0", 0, v);
         push("rnd_busy0", 2, {31'b0, b});
         mdl_read(int'(bus.ra[1]), v, b);
         push("rnd_rd1", 1, v);
         push("rnd_busy1", 3, {31'b0, b});
         push("rnd_cnt", 4, 32'(mdl_cnt()));
         drain();
         mdl_commit();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register index width; depth = 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 SHALL have parameter NUM_RD, default 2, number of async read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, number of sync write ports (1..2).
REQ-005 SHALL have parameter SP_INIT, default 32'h7fffeffc, reset value of x2.
REQ-006 SHALL have parameter GP_INIT, default 32'h10008000, reset value of x3.
REQ-007 SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding.
REQ-008 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-010 SHALL have port ra, input, NUM_RD x ADDRESS_WIDTH, read addresses.
REQ-011 SHALL have port rd, output, NUM_RD x DATA_WIDTH, read data.
REQ-012 SHALL have port rd_busy, output, NUM_RD, which flags a pending write on the read register.
REQ-013 SHALL have port we, input, NUM_WR, write enables.
REQ-014 SHALL have port wa, input, NUM_WR x ADDRESS_WIDTH, write addresses.
REQ-015 SHALL have port wd, input, NUM_WR x DATA_WIDTH, write data.
REQ-016 SHALL have port iss_valid, input, 1, which marks iss_addr as pending a write (scoreboard set).
REQ-017 SHALL have port iss_addr, input, ADDRESS_WIDTH, destination being issued.
REQ-018 SHALL have port busy_cnt, output, ADDRESS_WIDTH+1, number of registers currently pending.

Function
REQ-019 Reads SHALL be combinational; ra[i]==0 returns 0 and rd_busy[i]=0.
REQ-020 Writes SHALL commit on the rising clk edge when we[j]=1; writes to x0 are discarded.
REQ-021 When both write ports target the same nonzero address, port NUM_WR-1 SHALL win.
REQ-022 With BYPASS=1, rd[i] SHALL return wd[j] combinationally when we[j]=1 and wa[j]==ra[i]!=0, following the REQ-021 priority; with BYPASS=0, rd[i] returns the stored value.
REQ-023 A scoreboard of 2**ADDRESS_WIDTH busy bits SHALL exist; bit 0 is constant 0.
REQ-024 A write commit (we[j]=1) SHALL clear busy[wa[j]] at the same edge.
REQ-025 iss_valid=1 with iss_addr!=0 SHALL set busy[iss_addr] at the edge; set beats a same-edge clear of the same address.
REQ-026 iss_valid to an already-busy register SHALL leave it busy; busy_cnt is unchanged.
REQ-027 rd_busy[i] SHALL equal busy[ra[i]]; with BYPASS=1 it is forced 0 when a same-cycle write to ra[i] exists.
REQ-028 busy_cnt SHALL equal the population count of busy bits, maintained as a registered counter (+1 per new set, -1 per effective clear, net per edge); it never exceeds 2**ADDRESS_WIDTH-1.
REQ-029 A write to a non-busy register SHALL update data and leave busy_cnt unchanged.

Reset
REQ-030 rst_n=0 SHALL asynchronously set all registers to 0 except x2=SP_INIT and x3=GP_INIT.
REQ-031 rst_n=0 SHALL asynchronously clear all busy bits and set busy_cnt=0; rd_busy reads 0.
REQ-032 Reset asserted mid-issue or mid-write SHALL discard that operation; first update occurs on the first rising edge after rst_n deasserts.

Structure
REQ-033 A shared package rf_pkg SHALL hold the default ADDRESS_WIDTH/DATA_WIDTH, the SP_INIT/GP_INIT constants and the x0/x2/x3 index constants.
REQ-034 The scoreboard (busy bits plus counter) SHALL be a sub-module rf_scoreboard; the data array and bypass muxing stay in reg_file_sb.

Verification
REQ-035 Reset: rst_n=0 then 1; ra0=2, ra1=3 -> rd0=32'h7fffeffc, rd1=32'h10008000; ra0=5 -> 0; busy_cnt=0.
REQ-036 x0: we0=1, wa0=0, wd0=32'hdeadbeef; iss_addr=0 -> ra0=0 gives 0, rd_busy0=0, busy_cnt=0.
REQ-037 Bypass and conflict: we0/we1=1, wa=7/7, wd=32'h11/32'h22, ra0=7 -> same cycle rd0=32'h22 (BYPASS=1); next cycle stored value 32'h22.
REQ-038 Scoreboard: issue x5 -> busy_cnt=1, rd_busy for ra=5 is 1; write x5=32'hA5 -> same cycle rd_busy=0 and rd=32'hA5; next cycle busy_cnt=0.
REQ-039 Simultaneous events: x9 busy; same edge iss x9 and we0 to x9 -> x9 stays busy, busy_cnt unchanged; iss x10 plus write x9 in one edge -> busy_cnt net 0.
REQ-040 Async reset mid-operation: issue x4..x8 (busy_cnt=5), assert rst_n=0 between edges -> busy_cnt=0 immediately, x4 reads 0.
